multi_interval_timer: RTL and testbench

Parametrised multi-channel interval timer on a 16-bit Avalon-MM slave, the successor to the single-channel system timer in the Nios subsystem. Provides NUM_CH independent down-counters of CNT_W bits, each with its own period, per-channel clock prescaler, one-shot/continuous mode, snapshot and interrupt enable. All channels drive one shared level interrupt plus a per-channel interrupt vector.

---
 rtl/multi_interval_timer.sv | 148 ++++++++++++++
 tb/tb_multi_interval_timer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/multi_interval_timer.sv
// Multi-channel interval timer on a 16-bit Avalon-MM slave.
// Each channel has a prescaled down-counter, a period, a snapshot and an interrupt enable.
module multi_interval_timer #(
    parameter int          NUM_CH       = 4,
    parameter int          CNT_W        = 32,
    parameter int          PRESC_W      = 8,
    parameter logic [31:0] RESET_PERIOD = 32'h0003_0D3F,
    parameter int          ADDR_W       = $clog2(NUM_CH) + 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [15:0]       writedata,
    output logic [15:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec
);

    localparam int HI_W = CNT_W - 16;

    logic [CNT_W-1:0]   r_period    [NUM_CH];
    logic [CNT_W-1:0]   r_cnt       [NUM_CH];
    logic [CNT_W-1:0]   r_snap      [NUM_CH];
    logic [PRESC_W-1:0] r_presc_cnt [NUM_CH];
    logic [PRESC_W-1:0] r_prescale  [NUM_CH];
    logic [3:0]         r_ctrl      [NUM_CH];
    logic [NUM_CH-1:0]  r_to;
    logic [NUM_CH-1:0]  r_run;
    logic [NUM_CH-1:0]  r_force;
    logic [15:0]        r_readdata;

    logic               w_wr;
    logic [2:0]         w_reg;
    int                 w_ch;
    logic [NUM_CH-1:0]  w_sel;
    logic [NUM_CH-1:0]  w_tick;
    logic [NUM_CH-1:0]  w_tmo;
    logic [NUM_CH-1:0]  w_start;
    logic [NUM_CH-1:0]  w_stop;
    logic [15:0]        w_rdata;

    assign w_wr  = chipselect & ~write_n;
    assign w_reg = address[2:0];
    assign w_ch  = int'(address >> 3);

    always_comb begin
        w_sel   = '0;
        w_tick  = '0;
        w_tmo   = '0;
        w_start = '0;
        w_stop  = '0;
        irq_vec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_sel[i]   = w_wr && (w_ch == i);
            w_tick[i]  = r_run[i] && (r_presc_cnt[i] == r_prescale[i]);
            // A forced reload replaces whatever the tick would have done.
            w_tmo[i]   = w_tick[i] && (r_cnt[i] == '0) && !r_force[i];
            w_start[i] = w_sel[i] && (w_reg == 3'd1) && writedata[2];
            w_stop[i]  = w_sel[i] && (w_reg == 3'd1) && writedata[3];
            irq_vec[i] = r_to[i] & r_ctrl[i][0];
        end
    end

    assign irq = |irq_vec;

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch == i) begin
                case (w_reg)
                    3'd0:    w_rdata = {14'b0, r_run[i], r_to[i]};
                    3'd1:    w_rdata = {12'b0, r_ctrl[i]};
                    3'd2:    w_rdata = r_period[i][15:0];
                    3'd3:    w_rdata = 16'(r_period[i][CNT_W-1:16]);
                    3'd4:    w_rdata = r_snap[i][15:0];
                    3'd5:    w_rdata = 16'(r_snap[i][CNT_W-1:16]);
                    3'd6:    w_rdata = 16'(r_prescale[i]);
                    default: w_rdata = 16'(irq_vec);
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
            r_to       <= '0;
            r_run      <= '0;
            r_force    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_period[i]    <= RESET_PERIOD[CNT_W-1:0];
                r_cnt[i]       <= RESET_PERIOD[CNT_W-1:0];
                r_snap[i]      <= '0;
                r_presc_cnt[i] <= '0;
                r_prescale[i]  <= '0;
                r_ctrl[i]      <= '0;
            end
        end else begin
            r_readdata <= w_rdata;
            for (int i = 0; i < NUM_CH; i++) begin
                r_force[i] <= w_sel[i] && ((w_reg == 3'd2) || (w_reg == 3'd3));

                if (r_force[i]) begin
                    r_cnt[i]       <= r_period[i];
                    r_presc_cnt[i] <= '0;
                end else if (w_tick[i]) begin
                    r_presc_cnt[i] <= '0;
                    if (r_cnt[i] == '0)
                        r_cnt[i] <= r_period[i];
                    else
                        r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end else if (r_run[i]) begin
                    r_presc_cnt[i] <= r_presc_cnt[i] + PRESC_W'(1);
                end

                if (w_start[i])
                    r_run[i] <= 1'b1;
                else if (r_force[i] || w_stop[i])
                    r_run[i] <= 1'b0;
                else if (w_tmo[i] && !r_ctrl[i][1])
                    r_run[i] <= 1'b0;

                // Software clear has priority over a timeout on the same edge.
                if (w_sel[i] && (w_reg == 3'd0))
                    r_to[i] <= 1'b0;
                else if (w_tmo[i])
                    r_to[i] <= 1'b1;

                if (w_sel[i]) begin
                    case (w_reg)
                        3'd1:    r_ctrl[i] <= writedata[3:0];
                        3'd2:    r_period[i][15:0] <= writedata;
                        3'd3:    r_period[i][CNT_W-1:16] <= writedata[HI_W-1:0];
                        3'd4:    r_snap[i] <= r_cnt[i];
                        3'd5:    r_snap[i] <= r_cnt[i];
                        3'd6:    r_prescale[i] <= writedata[PRESC_W-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    assign readdata = r_readdata;

endmodule

// File: tb/tb_multi_interval_timer.sv
// Directed bench for multi_interval_timer: bus accesses happen on falling edges,
// every expected value below is worked out by hand from the register behaviour.
module tb_multi_interval_timer;

    logic        clk;
    logic        reset_n;
    logic        chipselect;
    logic        write_n;
    logic [4:0]  address;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;
    logic [3:0]  irq_vec;

    int n_checks = 0;
    int n_fail   = 0;

    multi_interval_timer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .write_n    (write_n),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .irq_vec    (irq_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "bench did not finish");
    end

    function automatic logic [4:0] a(input int ch, input int r);
        return 5'(ch * 8 + r);
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] addr, input logic [15:0] data);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = addr;
        writedata  = data;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rdchk(input logic [4:0] addr, input logic [15:0] exp, input string tag);
        address = addr;
        @(negedge clk);
        check(tag, 32'(readdata), 32'(exp));
    endtask

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;

        // Reset state
        #12;
        check("rst_readdata", 32'(readdata), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_irq_vec", 32'(irq_vec), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step(1);
        rdchk(a(0, 2), 16'h0D3F, "rst_period_l");
        rdchk(a(0, 3), 16'h0003, "rst_period_h");
        rdchk(a(0, 0), 16'h0000, "rst_status");
        check("rst_irq_after", 32'(irq), 32'h0);

        // One-shot on ch1: period 9, prescale 0
        wr(a(1, 2), 16'd9);
        wr(a(1, 3), 16'd0);
        wr(a(1, 6), 16'd0);
        wr(a(1, 1), 16'h5);
        step(9);
        check("os_irq_early", 32'(irq), 32'h0);
        step(1);
        check("os_irq_at10", 32'(irq), 32'h1);
        check("os_vec_at10", 32'(irq_vec), 32'h2);
        rdchk(a(1, 0), 16'h0001, "os_status");
        wr(a(1, 0), 16'h0);
        check("os_irq_clr", 32'(irq), 32'h0);

        // Continuous on ch2: period 3, prescale 2 -> timeout every 12 clks
        wr(a(2, 2), 16'd3);
        wr(a(2, 3), 16'd0);
        wr(a(2, 6), 16'd2);
        wr(a(2, 1), 16'h6);
        step(11);
        for (int p = 0; p < 5; p++) begin
            rdchk(a(2, 0), 16'h2, $sformatf("cont_pre%0d", p));
            rdchk(a(2, 0), 16'h3, $sformatf("cont_to%0d", p));
            wr(a(2, 0), 16'h0);
            if (p < 4) step(9);
        end
        // Stop lands on a tick edge: 3 -> 2, then frozen
        wr(a(2, 1), 16'h8);
        rdchk(a(2, 0), 16'h0, "stop_status");
        wr(a(2, 4), 16'h0);
        rdchk(a(2, 4), 16'h0002, "stop_snap1");
        step(5);
        wr(a(2, 4), 16'h0);
        rdchk(a(2, 4), 16'h0002, "stop_snap2");
        rdchk(a(2, 1), 16'h0008, "stop_ctrl");

        // Status clear on the timeout edge of ch1 (counter back at 9)
        wr(a(1, 1), 16'h5);
        step(9);
        wr(a(1, 0), 16'h0);
        check("clr_vs_to_irq", 32'(irq), 32'h0);
        rdchk(a(1, 0), 16'h0, "clr_vs_to_status");

        // Period write while running
        wr(a(1, 1), 16'h6);
        step(3);
        wr(a(1, 2), 16'h0020);
        rdchk(a(1, 0), 16'h2, "pw_run_still");
        wr(a(1, 4), 16'h0);
        rdchk(a(1, 4), 16'h0020, "pw_cnt_loaded");
        rdchk(a(1, 0), 16'h0, "pw_run_cleared");

        // START and STOP together
        wr(a(1, 1), 16'hC);
        rdchk(a(1, 0), 16'h2, "startstop_run");
        rdchk(a(1, 1), 16'hC, "startstop_ctrl");
        wr(a(1, 1), 16'h8);
        rdchk(a(1, 0), 16'h0, "stop_ch1");

        // Multi-channel: ch0 and ch3, period 4, ITO on ch3 only
        wr(a(0, 2), 16'd4);
        wr(a(0, 3), 16'd0);
        wr(a(3, 2), 16'd4);
        wr(a(3, 3), 16'd0);
        wr(a(0, 1), 16'h4);
        wr(a(3, 1), 16'h5);
        step(4);
        check("mc_vec_ch0_only", 32'(irq_vec), 32'h0);
        step(1);
        check("mc_vec", 32'(irq_vec), 32'h8);
        check("mc_irq", 32'(irq), 32'h1);
        rdchk(a(1, 7), 16'h0008, "mc_pend_ch1");
        rdchk(a(3, 7), 16'h0008, "mc_pend_ch3");
        rdchk(a(0, 0), 16'h0001, "mc_ch0_status");

        // Snapshot of 0x12345 while ch0 counts down from 0x12350
        wr(a(0, 0), 16'h0);
        wr(a(0, 2), 16'h2350);
        wr(a(0, 3), 16'h0001);
        wr(a(0, 1), 16'h6);
        step(11);
        wr(a(0, 4), 16'h0);
        rdchk(a(0, 4), 16'h2345, "snap_l");
        rdchk(a(0, 5), 16'h0001, "snap_h");
        step(5);
        rdchk(a(0, 4), 16'h2345, "snap_l_stable");
        rdchk(a(0, 5), 16'h0001, "snap_h_stable");

        // Asynchronous reset mid-count, with ch3 interrupt still pending
        check("pre_rst_irq", 32'(irq), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_irq", 32'(irq), 32'h0);
        check("arst_readdata", 32'(readdata), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step(3);
        rdchk(a(0, 0), 16'h0, "arst_status");
        rdchk(a(0, 2), 16'h0D3F, "arst_period_l");
        rdchk(a(0, 5), 16'h0000, "arst_snap_h");
        check("arst_irq_after", 32'(irq), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
